// File: rtl/alu_stim_pkg.sv
// Shared constants for the ALU stimulus driver:
// opcodes, walk order, directed operands, LFSR step.
package alu_stim_pkg;

  localparam logic [4:0] ADD  = 5'b00000;
  localparam logic [4:0] SUB  = 5'b00001;
  localparam logic [4:0] SLL  = 5'b00010;
  localparam logic [4:0] BXOR = 5'b00011;
  localparam logic [4:0] SRL  = 5'b00100;
  localparam logic [4:0] SRA  = 5'b00101;
  localparam logic [4:0] BOR  = 5'b00110;
  localparam logic [4:0] BAND = 5'b00111;
  localparam logic [4:0] SLTU = 5'b01000;
  localparam logic [4:0] BNE  = 5'b01001;
  localparam logic [4:0] BEQ  = 5'b01010;
  localparam logic [4:0] LUI  = 5'b01011;
  localparam logic [4:0] MUL  = 5'b01100;
  localparam logic [4:0] BLT  = 5'b01101;
  localparam logic [4:0] BGE  = 5'b01110;
  localparam logic [4:0] BLTU = 5'b10000;
  localparam logic [4:0] BGEU = 5'b10001;
  localparam logic [4:0] DIV  = 5'b10010;
  localparam logic [4:0] REM  = 5'b10100;

  localparam int NUM_OPS = 19;

  localparam logic [4:0] OP_WALK [NUM_OPS] = '{
    ADD, SUB, SLL, BXOR, SRL, SRA, BOR, BAND,
    SLTU, BNE, BEQ, LUI, MUL, BLT, BGE,
    BLTU, BGEU, DIV, REM
  };

  localparam int NUM_DIRECTED = 4;

  localparam logic [63:0] DIR_A [NUM_DIRECTED] = '{
    64'd0,
    64'hFFFF_FFFF_FFFF_FFFF,
    64'h8000_0000_0000_0000,
    64'd5
  };

  localparam logic [63:0] DIR_B [NUM_DIRECTED] = '{
    64'd0,
    64'd1,
    64'hFFFF_FFFF_FFFF_FFFF,
    64'd3
  };

  localparam logic [63:0] LFSR_MASK = 64'hD800_0000_0000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_DRIVE,
    S_FIN
  } state_t;

  function automatic logic [63:0] lfsr_step(
    input logic [63:0] s
  );
    return {1'b0, s[63:1]} ^ (s[0] ? LFSR_MASK : 64'd0);
  endfunction

  function automatic logic is_shift(
    input logic [4:0] op
  );
    return (op == SLL) || (op == SRL) || (op == SRA);
  endfunction

  function automatic logic is_divrem(
    input logic [4:0] op
  );
    return (op == DIV) || (op == REM);
  endfunction

endpackage

// File: rtl/alu_lfsr64.sv
// 64-bit right-shift Galois LFSR; one step advances
// the state by two so a random vector gets A and B.
module alu_lfsr64
  import alu_stim_pkg::*;
#(
  parameter logic [63:0] SEED = 64'hACE1_2468_BDF1_3579
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  output logic [63:0] next1,
  output logic [63:0] next2
);

  logic [63:0] state;

  assign next1 = lfsr_step(state);
  assign next2 = lfsr_step(next1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (load) begin
      state <= SEED;
    end else if (step) begin
      state <= next2;
    end
  end

endmodule

// File: rtl/alu_stim_driver.sv
// Opcode-walking stimulus source for the 64-bit ALU:
// directed corners then LFSR vectors, valid/ready out.
module alu_stim_driver
  import alu_stim_pkg::*;
#(
  parameter int          NUM_RAND = 4,
  parameter logic [63:0] SEED     = 64'hACE1_2468_BDF1_3579,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             rdy,
  output logic             vld,
  output logic [4:0]       opcode,
  output logic [63:0]      A,
  output logic [63:0]      B,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_cnt
);

  localparam int PER   = NUM_DIRECTED + NUM_RAND;
  localparam int SUB_W = $clog2(PER);

  state_t           state;
  logic [4:0]       idx;
  logic [SUB_W-1:0] sub;

  logic        start_ok;
  logic        is_rand;
  logic        last_sub;
  logic        last_vec;
  logic        accept;
  logic [63:0] r1;
  logic [63:0] r2;
  logic [4:0]  nxt_op;
  logic [63:0] nxt_a;
  logic [63:0] raw_b;
  logic [63:0] nxt_b;

  assign start_ok = (state == S_IDLE) && start;
  assign is_rand  = sub >= SUB_W'(NUM_DIRECTED);
  assign last_sub = sub == SUB_W'(PER - 1);
  assign last_vec = last_sub && (idx == 5'(NUM_OPS - 1));
  assign accept   = (state == S_DRIVE) && vld && rdy;

  alu_lfsr64 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_ok),
    .step  ((state == S_LOAD) && is_rand),
    .next1 (r1),
    .next2 (r2)
  );

  always_comb begin
    nxt_op = OP_WALK[idx];
    nxt_a  = is_rand ? r1 : DIR_A[sub[1:0]];
    raw_b  = is_rand ? r2 : DIR_B[sub[1:0]];
    nxt_b  = raw_b;
    unique case (1'b1)
      is_shift(nxt_op):
        nxt_b = {58'd0, raw_b[5:0]};
      is_divrem(nxt_op) && (raw_b == 64'd0):
        nxt_b = 64'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      vld     <= 1'b0;
      opcode  <= '0;
      A       <= '0;
      B       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      vec_cnt <= '0;
      idx     <= '0;
      sub     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start_ok) begin
            busy    <= 1'b1;
            done    <= 1'b0;
            vec_cnt <= '0;
            idx     <= '0;
            sub     <= '0;
            state   <= S_LOAD;
          end
        end
        S_LOAD: begin
          opcode <= nxt_op;
          A      <= nxt_a;
          B      <= nxt_b;
          vld    <= 1'b1;
          state  <= S_DRIVE;
        end
        S_DRIVE: begin
          if (accept) begin
            vld <= 1'b0;
            if (vec_cnt != '1) begin
              vec_cnt <= vec_cnt + 1'b1;
            end
            if (last_sub) begin
              sub <= '0;
              idx <= idx + 5'd1;
            end else begin
              sub <= sub + 1'b1;
            end
            state <= last_vec ? S_FIN : S_LOAD;
          end
        end
        S_FIN: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
